vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares one single-port synchronous VRAM between the video scan-out and a CPU-side
//  requester. Display fetches are driven by hpos/vpos/display_on from hvsync_generator
//  and always win; the CPU is served in the remaining cycles through a req/ack handshake.
//  Sits between hvsync_generator, the VRAM macro and the tile/pixel renderer.
// PARAMETERS
//  ADDR_W  13  VRAM address width
//  DATA_W  8   VRAM data width
//  COLS    80  cells per row; one cell = 8x8 pixels
// PORTS
//  clk         in   1       system/pixel clock
//  reset       in   1       asynchronous, active-high
//  hpos        in   10      horizontal position
//  vpos        in   10      vertical position
//  display_on  in   1       visible area flag
//  cpu_req     in   1       CPU access request; level, held until cpu_ack
//  cpu_we      in   1       1=write, 0=read; stable while cpu_req
//  cpu_addr    in   ADDR_W  CPU address; stable while cpu_req
//  cpu_wdata   in   DATA_W  write data; stable while cpu_req
//  cpu_ack     out  1       1-cycle pulse: request accepted, issued to VRAM this cycle
//  cpu_rdata   out  DATA_W  read data
//  cpu_rvalid  out  1       1-cycle pulse: cpu_rdata valid
//  mem_addr    out  ADDR_W  VRAM address (registered)
//  mem_we      out  1       VRAM write enable (registered)
//  mem_wdata   out  DATA_W  VRAM write data (registered)
//  mem_rdata   in   DATA_W  VRAM read data, valid 1 cycle after address sampled
//  pix_data    out  DATA_W  latest display cell byte
//  pix_strobe  out  1       1-cycle pulse: pix_data updated
// BEHAVIOUR
//  - Reset: every output 0, FSM in IDLE, read pipeline flags cleared. Reset during an
//    access discards it: no cpu_rvalid/pix_strobe ever issued for it.
//  - Cycle t = decision cycle. Display slot when display_on && hpos[2:0]==0.
//    Slot: mem_addr <= vpos[9:3]*COLS + hpos[9:3] (truncated to ADDR_W), mem_we <= 0.
//  - Else CPU grant if cpu_req && state==IDLE: mem_addr/we/wdata <= cpu_*,
//    cpu_ack=1 in t+1, FSM -> ACK.
//  - Else mem_we <= 0, mem_addr holds.
//  - FSM: IDLE -> ACK on CPU grant; ACK -> IDLE unconditionally. No grant while in ACK,
//    so a requester dropping cpu_req after seeing ack is never granted twice;
//    max CPU rate = 1 access / 2 cycles.
//  - Slot in the same cycle as pending cpu_req: display wins, CPU waits; ack delayed,
//    never lost. Slot during ACK is legal (display only).
//  - Read latency: data registered into pix_data/cpu_rdata at end of t+2, so
//    pix_strobe/cpu_rvalid are high in t+3. Display byte and CPU read never collide:
//    tags are carried per access.
//  - CPU writes produce no rvalid. cpu_rdata/pix_data hold between strobes.
//  - Worst-case CPU wait: 2 cycles in display area (1 per slot every 8 cycles);
//    blanking has no slots.
//  - Wrap: hpos/vpos are consumed as given; the address product is truncated, never
//    saturated.
// CONFIGURATION
//  VRAM_ARB_STATS_EN defined: extra output cpu_stall_cnt [15:0]. It increments each
//    cycle cpu_req=1 && no grant (slot or ACK state), saturates at 16'hFFFF, and is
//    cleared by reset.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. Reset held, random inputs -> all outputs 0; release with display_on=0 and no req
//     -> mem_we stays 0.
//  2. display_on=1, vpos=16, hpos=24 -> mem_addr=2*80+3=163, mem_we=0 next cycle;
//     mem_rdata=8'hA5 -> pix_data=A5, pix_strobe=1 at t+3.
//  3. Blanking: cpu_req, we=1, addr=100, wdata=8'h3C -> cpu_ack 1 cycle later with
//     mem_we=1, mem_addr=100; req held 3 cycles -> exactly one ack.
//  4. cpu_req read at hpos=8 (slot) -> display issued first; ack at t+2;
//     cpu_rvalid with correct byte 2 cycles after ack.
//  5. Back-to-back CPU reads at addr 5,6 in blanking -> acks 2 cycles apart,
//     two rvalids in order.
//  6. Read granted, reset asserted 1 cycle after ack -> no cpu_rvalid; with
//     VRAM_ARB_STATS_EN, case 4 -> cpu_stall_cnt=1.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch slots always win, CPU served via req/ack in free cycles.
// Optional stall counter output cpu_stall_cnt when VRAM_ARB_STATS_EN is defined.
module vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int COLS   = 80
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hpos,
  input  logic [9:0]        vpos,
  input  logic              display_on,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_strobe
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       cpu_stall_cnt
`endif
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              rd1_disp_q, rd1_disp_d, rd1_cpu_q, rd1_cpu_d;
  logic              rd2_disp_q, rd2_disp_d, rd2_cpu_q, rd2_cpu_d;
  logic [DATA_W-1:0] pix_data_q, pix_data_d;
  logic              pix_strobe_q, pix_strobe_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;

  logic              slot, grant, stall;
  logic [ADDR_W-1:0] slot_addr;
  logic              vpos_fine_unused;

  // Cell address wraps modulo 2**ADDR_W; the row is the pixel row divided by 8.
  assign slot_addr        = ADDR_W'(vpos[9:3]) * ADDR_W'(COLS) + ADDR_W'(hpos[9:3]);
  assign vpos_fine_unused = ^vpos[2:0];

  assign slot  = display_on && (hpos[2:0] == 3'd0);
  assign grant = !slot && cpu_req && (state_q == IDLE);
  assign stall = cpu_req && !grant;

  always_comb begin
    state_d      = IDLE;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    cpu_ack_d    = 1'b0;
    rd1_disp_d   = 1'b0;
    rd1_cpu_d    = 1'b0;
    if (slot) begin
      mem_addr_d = slot_addr;
      rd1_disp_d = 1'b1;
    end else if (grant) begin
      mem_addr_d  = cpu_addr;
      mem_we_d    = cpu_we;
      mem_wdata_d = cpu_wdata;
      cpu_ack_d   = 1'b1;
      state_d     = ACK;
      rd1_cpu_d   = !cpu_we;
    end
    // Tags follow the access: stage 1 aligns with mem_addr, stage 2 with mem_rdata.
    rd2_disp_d   = rd1_disp_q;
    rd2_cpu_d    = rd1_cpu_q;
    pix_strobe_d = rd2_disp_q;
    cpu_rvalid_d = rd2_cpu_q;
    pix_data_d   = rd2_disp_q ? mem_rdata : pix_data_q;
    cpu_rdata_d  = rd2_cpu_q  ? mem_rdata : cpu_rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      rd1_disp_q   <= 1'b0;
      rd1_cpu_q    <= 1'b0;
      rd2_disp_q   <= 1'b0;
      rd2_cpu_q    <= 1'b0;
      pix_data_q   <= '0;
      pix_strobe_q <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_ack_q    <= cpu_ack_d;
      rd1_disp_q   <= rd1_disp_d;
      rd1_cpu_q    <= rd1_cpu_d;
      rd2_disp_q   <= rd2_disp_d;
      rd2_cpu_q    <= rd2_cpu_d;
      pix_data_q   <= pix_data_d;
      pix_strobe_q <= pix_strobe_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
    end
  end

  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign pix_data   = pix_data_q;
  assign pix_strobe = pix_strobe_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign cpu_stall_cnt = stall_cnt_q;
`else
  logic stall_unused;
  assign stall_unused = stall;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous VRAM model.
// Inputs change and outputs are sampled on the falling edge.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hpos, vpos;
  logic        display_on;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack, cpu_rvalid, mem_we, pix_strobe;
  logic [7:0]  cpu_rdata, mem_wdata, mem_rdata, pix_data;
  logic [12:0] mem_addr;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] cpu_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] vram [0:8191];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= vram[mem_addr];
    if (mem_we) vram[mem_addr] <= mem_wdata;
  end

  vram_arbiter dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_strobe(pix_strobe)
`ifdef VRAM_ARB_STATS_EN
    , .cpu_stall_cnt(cpu_stall_cnt)
`endif
  );

  task automatic idle_inputs();
    hpos = 10'd1; vpos = 10'd0; display_on = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  task automatic reset_pulse();
    @(negedge clk); idle_inputs(); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [47:0] outs;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hpos = 10'($urandom); vpos = 10'($urandom); display_on = 1'($urandom);
      cpu_req = 1'($urandom); cpu_we = 1'($urandom);
      cpu_addr = 13'($urandom); cpu_wdata = 8'($urandom);
      outs = {cpu_ack, cpu_rdata, cpu_rvalid, mem_addr, mem_we, mem_wdata, pix_data, pix_strobe};
      checks++;
      if (outs !== 48'd0) begin
        errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
      end
    end
    @(negedge clk); idle_inputs(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0 || cpu_ack !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle: mem_we=%b ack=%b expected 0 0", mem_we, cpu_ack);
      end
    end
  endtask

  task automatic display_fetch(input logic [9:0] hp, input logic [9:0] vp,
                               input logic [12:0] exp_addr, input logic [7:0] exp_data,
                               input string name);
    @(negedge clk); hpos = hp; vpos = vp; display_on = 1'b1;
    @(negedge clk); display_on = 1'b0; hpos = hp + 10'd1;
    checks++;
    if (mem_addr !== exp_addr || mem_we !== 1'b0) begin
      errors++; $display("FAIL %s_addr: got %0d we=%b expected %0d we=0", name, mem_addr, mem_we, exp_addr);
    end
    @(negedge clk);
    checks++;
    if (pix_strobe !== 1'b0) begin
      errors++; $display("FAIL %s_early_strobe: got %b expected 0", name, pix_strobe);
    end
    @(negedge clk);
    checks++;
    if (pix_strobe !== 1'b1 || pix_data !== exp_data) begin
      errors++; $display("FAIL %s_pix: strobe=%b data=%h expected 1 %h", name, pix_strobe, pix_data, exp_data);
    end
    @(negedge clk);
    checks++;
    if (pix_strobe !== 1'b0 || pix_data !== exp_data) begin
      errors++; $display("FAIL %s_hold: strobe=%b data=%h expected 0 %h", name, pix_strobe, pix_data, exp_data);
    end
  endtask

  task automatic test_display();
    display_fetch(10'd24, 10'd16, 13'd163, 8'hA5, "disp");
  endtask

  task automatic test_wrap();
    // 127*80+127 = 10287, truncated to 13 bits = 2095; vram[2095] = 8'h2F ^ 8'h5A
    display_fetch(10'd1016, 10'd1023, 13'd2095, 8'h75, "wrap");
  endtask

  task automatic test_cpu_write();
    int acks, rvs;
    acks = 0; rvs = 0;
    @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'd100; cpu_wdata = 8'h3C;
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 13'd100 || mem_wdata !== 8'h3C) begin
      errors++; $display("FAIL wr_issue: ack=%b we=%b addr=%0d wdata=%h expected 1 1 100 3c",
                         cpu_ack, mem_we, mem_addr, mem_wdata);
    end
    if (cpu_ack === 1'b1) acks++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) acks++;
      if (cpu_rvalid === 1'b1) rvs++;
      if (i == 0) cpu_req = 1'b0;
    end
    checks++;
    if (acks != 1) begin
      errors++; $display("FAIL wr_single_ack: got %0d acks expected 1", acks);
    end
    checks++;
    if (rvs != 0) begin
      errors++; $display("FAIL wr_no_rvalid: got %0d rvalids expected 0", rvs);
    end
    checks++;
    if (vram[100] !== 8'h3C) begin
      errors++; $display("FAIL wr_mem: got %h expected 3c", vram[100]);
    end
  endtask

  task automatic test_slot_collision();
    reset_pulse();
    @(negedge clk);
    hpos = 10'd8; vpos = 10'd0; display_on = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'd200;
    @(negedge clk);
    display_on = 1'b0; hpos = 10'd9;
    checks++;
    if (mem_addr !== 13'd1 || cpu_ack !== 1'b0) begin
      errors++; $display("FAIL col_display_first: addr=%0d ack=%b expected 1 0", mem_addr, cpu_ack);
    end
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b1 || mem_addr !== 13'd200) begin
      errors++; $display("FAIL col_ack: ack=%b addr=%0d expected 1 200", cpu_ack, mem_addr);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (pix_strobe !== 1'b1 || pix_data !== 8'h5B || cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL col_pix: strobe=%b data=%h rvalid=%b expected 1 5b 0",
                         pix_strobe, pix_data, cpu_rvalid);
    end
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h92 || pix_strobe !== 1'b0) begin
      errors++; $display("FAIL col_cpu_read: rvalid=%b data=%h strobe=%b expected 1 92 0",
                         cpu_rvalid, cpu_rdata, pix_strobe);
    end
`ifdef VRAM_ARB_STATS_EN
    checks++;
    if (cpu_stall_cnt !== 16'd1) begin
      errors++; $display("FAIL stall_cnt: got %0d expected 1", cpu_stall_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'd5;
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b1 || mem_addr !== 13'd5) begin
      errors++; $display("FAIL b2b_ack1: ack=%b addr=%0d expected 1 5", cpu_ack, mem_addr);
    end
    cpu_addr = 13'd6;
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: ack=%b expected 0", cpu_ack);
    end
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b1 || mem_addr !== 13'd6 || cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5F) begin
      errors++; $display("FAIL b2b_ack2_rd1: ack=%b addr=%0d rvalid=%b data=%h expected 1 6 1 5f",
                         cpu_ack, mem_addr, cpu_rvalid, cpu_rdata);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h5F) begin
      errors++; $display("FAIL b2b_hold: rvalid=%b data=%h expected 0 5f", cpu_rvalid, cpu_rdata);
    end
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5C) begin
      errors++; $display("FAIL b2b_rd2: rvalid=%b data=%h expected 1 5c", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_reset_abort();
    int rvs;
    rvs = 0;
    @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'd7;
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b1) begin
      errors++; $display("FAIL abort_ack: got %b expected 1", cpu_ack);
    end
    cpu_req = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    if (cpu_rvalid === 1'b1) rvs++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cpu_rvalid === 1'b1) rvs++;
    end
    checks++;
    if (rvs != 0) begin
      errors++; $display("FAIL abort_no_rvalid: got %0d rvalids expected 0", rvs);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) vram[i] = 8'(i) ^ 8'h5A;
    vram[163] = 8'hA5;
    idle_inputs();
    test_reset();
    test_display();
    test_wrap();
    test_cpu_write();
    test_slot_collision();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
